// File: rtl/ifm_pingpong_buffer_if.sv
// Pool-to-IFM-buffer-to-conv handshake and data bus.
// master = pool/conv side (drives writes, reads, release); slave = buffer.
interface ifm_pingpong_buffer_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int IFM_SIZE        = 5,
  parameter int NUMBER_OF_UNITS = 16,
  parameter int ADDRESS_SIZE    = $clog2(IFM_SIZE*IFM_SIZE)
) ();
  localparam int BUS_W = DATA_WIDTH*NUMBER_OF_UNITS;

  // write side (pool CU)
  logic                    wr_en;
  logic [ADDRESS_SIZE-1:0] wr_addr;
  logic [BUS_W-1:0]        wr_data;
  logic                    wr_done;
  logic                    conv_ready;
  logic                    end_to_previous;

  // read side (next conv layer)
  logic                    start_to_next;
  logic                    rd_en_A;
  logic                    rd_en_B;
  logic [ADDRESS_SIZE-1:0] rd_addr_A;
  logic [ADDRESS_SIZE-1:0] rd_addr_B;
  logic [BUS_W-1:0]        rd_data_A;
  logic [BUS_W-1:0]        rd_data_B;
  logic                    end_from_next;

  logic                    overflow;

  modport master (
    output wr_en, wr_addr, wr_data, wr_done,
    output rd_en_A, rd_en_B, rd_addr_A, rd_addr_B, end_from_next,
    input  conv_ready, end_to_previous, start_to_next,
    input  rd_data_A, rd_data_B, overflow
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done,
    input  rd_en_A, rd_en_B, rd_addr_A, rd_addr_B, end_from_next,
    output conv_ready, end_to_previous, start_to_next,
    output rd_data_A, rd_data_B, overflow
  );
endinterface

// File: rtl/ifm_pingpong_buffer.sv
// Double-banked IFM buffer: the pool fills one bank while the conv layer
// reads the other through two registered read ports.

// One lane's storage: two banks of DEPTH words, one write port, two
// registered read ports. Out-of-range reads are squashed to zero upstream
// via rd_ok_*.
module ifm_pingpong_lane #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 25,
  parameter int ADDRESS_SIZE = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    wr_bank,
  input  logic [ADDRESS_SIZE-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_bank,
  input  logic                    rd_en_a,
  input  logic                    rd_ok_a,
  input  logic [ADDRESS_SIZE-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0]   rd_data_a,
  input  logic                    rd_en_b,
  input  logic                    rd_ok_b,
  input  logic [ADDRESS_SIZE-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0]   rd_data_b
);
  logic [DATA_WIDTH-1:0] mem [2][DEPTH];

  // storage is deliberately not reset; ownership is tracked by the control
  always_ff @(posedge clk)
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;

  // port A: registered read, holds while rd_en_a is low
  always_ff @(posedge clk or negedge reset)
    if (!reset)       rd_data_a <= '0;
    else if (rd_en_a) rd_data_a <= rd_ok_a ? mem[rd_bank][rd_addr_a] : '0;

  // port B: same as A, independent address
  always_ff @(posedge clk or negedge reset)
    if (!reset)       rd_data_b <= '0;
    else if (rd_en_b) rd_data_b <= rd_ok_b ? mem[rd_bank][rd_addr_b] : '0;
endmodule

module ifm_pingpong_buffer #(
  parameter int DATA_WIDTH      = 32,
  parameter int IFM_SIZE        = 5,
  parameter int NUMBER_OF_UNITS = 16,
  parameter int ADDRESS_SIZE    = $clog2(IFM_SIZE*IFM_SIZE)
) (
  input logic                 clk,
  input logic                 reset,
  ifm_pingpong_buffer_if.slave bus
);
  localparam int DEPTH = IFM_SIZE*IFM_SIZE;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_BUSY  = 2'd2
  } rd_state_e;

  rd_state_e state, state_nxt;

  logic       wb;          // bank the pool is filling
  logic       rb;          // bank presented to the conv layer
  logic [1:0] count;       // completed banks not yet released (0..2)
  logic       overflow_q;
  logic [1:0] rel_pipe;    // release delayed two edges -> end_to_previous

  logic full, rel_now, done_ok, wr_commit;
  logic wr_in_range, rd_ok_a, rd_ok_b;

  logic [NUMBER_OF_UNITS-1:0][DATA_WIDTH-1:0] wr_lanes, rd_lanes_a, rd_lanes_b;

  assign full        = (count == 2'd2);
  assign rel_now     = (state == R_BUSY) && bus.end_from_next;
  // a release in the same cycle frees the bank wr_done is completing into
  assign done_ok     = bus.wr_done && (!full || rel_now);
  assign wr_in_range = int'(bus.wr_addr)   < DEPTH;
  assign rd_ok_a     = int'(bus.rd_addr_A) < DEPTH;
  assign rd_ok_b     = int'(bus.rd_addr_B) < DEPTH;
  // wb != rb whenever count < 2, so a committed write never lands in the read bank
  assign wr_commit   = bus.wr_en && !full && wr_in_range;

  assign bus.conv_ready      = !full;
  assign bus.start_to_next   = (state == R_START);
  assign bus.end_to_previous = rel_pipe[1];
  assign bus.overflow        = overflow_q;

  // read handoff FSM: state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= R_IDLE;
    else        state <= state_nxt;

  // read handoff FSM: announce a full bank, then wait for the consumer
  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE:  if (count != 2'd0) state_nxt = R_START;
      R_START: state_nxt = R_BUSY;
      R_BUSY:  if (bus.end_from_next) state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  // bank ownership: wr_done hands wb over, release hands rb back
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wb    <= 1'b0;
      rb    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (done_ok) wb <= ~wb;
      if (rel_now) rb <= ~rb;
      case ({done_ok, rel_now})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end

  // sticky error: any write or completion attempted while both banks are full
  always_ff @(posedge clk or negedge reset)
    if (!reset) overflow_q <= 1'b0;
    else if ((bus.wr_en && full) || (bus.wr_done && full && !rel_now))
      overflow_q <= 1'b1;

  // end_to_previous fires the second edge after the release is sampled
  always_ff @(posedge clk or negedge reset)
    if (!reset) rel_pipe <= '0;
    else        rel_pipe <= {rel_pipe[0], rel_now};

  assign wr_lanes      = bus.wr_data;
  assign bus.rd_data_A = rd_lanes_a;
  assign bus.rd_data_B = rd_lanes_b;

  for (genvar k = 0; k < NUMBER_OF_UNITS; k++) begin : g_lane
    ifm_pingpong_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH       (DEPTH),
      .ADDRESS_SIZE(ADDRESS_SIZE)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_commit),
      .wr_bank  (wb),
      .wr_addr  (bus.wr_addr),
      .wr_data  (wr_lanes[k]),
      .rd_bank  (rb),
      .rd_en_a  (bus.rd_en_A),
      .rd_ok_a  (rd_ok_a),
      .rd_addr_a(bus.rd_addr_A),
      .rd_data_a(rd_lanes_a[k]),
      .rd_en_b  (bus.rd_en_B),
      .rd_ok_b  (rd_ok_b),
      .rd_addr_b(bus.rd_addr_B),
      .rd_data_b(rd_lanes_b[k])
    );
  end
endmodule

// File: tb/tb_ifm_pingpong_buffer.sv
// Bench for ifm_pingpong_buffer: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a frame-queue model.
module tb_ifm_pingpong_buffer;
  localparam int DW = 32, IFM = 5, N = 16, AW = 5, DEPTH = IFM*IFM, W = DW*N;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ifm_pingpong_buffer_if #(.DATA_WIDTH(DW), .IFM_SIZE(IFM), .NUMBER_OF_UNITS(N),
                           .ADDRESS_SIZE(AW)) bus ();

  ifm_pingpong_buffer #(.DATA_WIDTH(DW), .IFM_SIZE(IFM), .NUMBER_OF_UNITS(N),
                        .ADDRESS_SIZE(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chkb(string nm, logic act, logic exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %0b want %0b", nm, act, exp); end
  endtask

  task automatic chkd(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %0d want %0d", nm, act, exp); end
  endtask

  task automatic chkw(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %0h want %0h", nm, act, exp); end
  endtask

  // ---------------- model: pool of frame slots + queue of completed frames
  logic [W-1:0] fw [3][DEPTH];
  bit           fk [3][DEPTH];   // word written since the frame slot was opened
  int           q[$];            // completed frames, front = being presented
  int           fill;            // frame the pool is currently writing
  int           phase;           // 0 idle, 1 announcing, 2 consumer busy
  bit           rel_d1, rel_d2, m_ovf;
  logic [W-1:0] exp_a, exp_b;
  bit           kn_a, kn_b;

  function automatic void m_reset();
    q.delete();
    fill = 0;
    for (int s = 0; s < 3; s++) for (int a = 0; a < DEPTH; a++) fk[s][a] = 1'b0;
    phase = 0; rel_d1 = 0; rel_d2 = 0; m_ovf = 0;
    exp_a = '0; exp_b = '0; kn_a = 1; kn_b = 1;
  endfunction

  function automatic void m_read(input logic [AW-1:0] a, input int sz,
                                 output logic [W-1:0] e, output bit k);
    e = '0; k = 1'b0;
    if (int'(a) >= DEPTH) k = 1'b1;
    else if (sz > 0) begin e = fw[q[0]][a]; k = fk[q[0]][a]; end
  endfunction

  function automatic void m_step();
    int  sz0  = q.size();
    bit  full = (sz0 == 2);
    bit  rel  = (phase == 2) && bus.end_from_next;
    if (bus.rd_en_A) m_read(bus.rd_addr_A, sz0, exp_a, kn_a);
    if (bus.rd_en_B) m_read(bus.rd_addr_B, sz0, exp_b, kn_b);
    if (bus.wr_en) begin
      if (full) m_ovf = 1;
      else if (int'(bus.wr_addr) < DEPTH) begin
        fw[fill][bus.wr_addr] = bus.wr_data;
        fk[fill][bus.wr_addr] = 1'b1;
      end
    end
    if (rel) void'(q.pop_front());
    if (bus.wr_done) begin
      if (!full || rel) begin
        q.push_back(fill);
        for (int s = 0; s < 3; s++) begin
          bit used = 0;
          foreach (q[i]) if (q[i] == s) used = 1;
          if (!used) fill = s;
        end
        for (int a = 0; a < DEPTH; a++) fk[fill][a] = 1'b0;
      end else m_ovf = 1;
    end
    case (phase)
      0:       if (sz0 > 0) phase = 1;
      1:       phase = 2;
      default: if (bus.end_from_next) phase = 0;
    endcase
    rel_d2 = rel_d1;
    rel_d1 = rel;
  endfunction

  // compare process: advance the model on each edge, check just after it
  always @(posedge clk) begin
    if (!reset) m_reset();
    else        m_step();
    #1;
    chkb("m_conv_ready", bus.conv_ready, q.size() != 2);
    chkb("m_start", bus.start_to_next, phase == 1);
    chkb("m_end_prev", bus.end_to_previous, rel_d2);
    chkb("m_overflow", bus.overflow, m_ovf);
    if (kn_a) chkw("m_rd_a", bus.rd_data_A, exp_a);
    if (kn_b) chkw("m_rd_b", bus.rd_data_B, exp_b);
  end

  // ---------------- stimulus helpers
  function automatic logic [W-1:0] fword(int base, int a);
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(base + k*100 + a);
    return r;
  endfunction

  // start a new cycle with every strobe low
  task automatic cyc();
    @(negedge clk);
    bus.wr_en = 0; bus.wr_done = 0; bus.rd_en_A = 0; bus.rd_en_B = 0;
    bus.end_from_next = 0;
  endtask

  task automatic write_frame(int base);
    for (int a = 0; a < DEPTH; a++) begin
      cyc(); bus.wr_en = 1; bus.wr_addr = AW'(a); bus.wr_data = fword(base, a);
    end
    cyc(); bus.wr_done = 1;
  endtask

  task automatic wait_start(string nm);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin cyc(); seen = bus.start_to_next; end
    chkb(nm, seen, 1'b1);
  endtask

  task automatic do_reset();
    cyc(); reset = 0;
    cyc(); reset = 1;
    cyc();
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_done = 0; bus.rd_en_A = 0; bus.rd_en_B = 0;
    bus.end_from_next = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr_A = '0; bus.rd_addr_B = '0;
    repeat (3) @(negedge clk);
    reset = 1;
    cyc();
    chkb("rst_conv_ready", bus.conv_ready, 1'b1);
    chkb("rst_overflow", bus.overflow, 1'b0);

    // single frame: start two cycles after wr_done, then dual-port reads
    write_frame(0);
    cyc(); chkb("sf_start_e0", bus.start_to_next, 1'b0);
    cyc(); chkb("sf_start_e1", bus.start_to_next, 1'b1);
    cyc(); chkb("sf_start_e2", bus.start_to_next, 1'b0);
    bus.rd_en_A = 1; bus.rd_addr_A = 5'd3; bus.rd_en_B = 1; bus.rd_addr_B = 5'd24;
    cyc();
    chkd("sf_rd_a_lane5", bus.rd_data_A[5*DW +: DW], 32'd503);
    chkd("sf_rd_b_lane5", bus.rd_data_B[5*DW +: DW], 32'd524);
    bus.rd_en_B = 1; bus.rd_addr_B = 5'd25;
    cyc();
    chkd("sf_rd_a_hold", bus.rd_data_A[5*DW +: DW], 32'd503);
    chkw("sf_rd_b_oor", bus.rd_data_B, '0);
    bus.end_from_next = 1;
    cyc(); chkb("sf_endp_f0", bus.end_to_previous, 1'b0);
    cyc(); chkb("sf_endp_f1", bus.end_to_previous, 1'b1);
    cyc(); chkb("sf_endp_f2", bus.end_to_previous, 1'b0);

    // ping-pong: two frames queued, release, immediate re-announce
    write_frame(1000);
    write_frame(2000);
    cyc(); chkb("pp_conv_full", bus.conv_ready, 1'b0);
    bus.rd_en_A = 1; bus.rd_addr_A = 5'd7;
    cyc(); chkd("pp_rd_f0", bus.rd_data_A[3*DW +: DW], 32'd1307);
    bus.end_from_next = 1;
    cyc();
    cyc();
    chkb("pp_endp", bus.end_to_previous, 1'b1);
    chkb("pp_conv_free", bus.conv_ready, 1'b1);
    chkb("pp_start2", bus.start_to_next, 1'b1);
    bus.rd_en_B = 1; bus.rd_addr_B = 5'd12;
    cyc(); chkd("pp_rd_f1", bus.rd_data_B[9*DW +: DW], 32'd2912);

    // overflow: fill second bank, then write and complete while full
    write_frame(3000);
    cyc(); bus.wr_en = 1; bus.wr_addr = 5'd0; bus.wr_data = '1;
    cyc(); bus.wr_done = 1;
    cyc();
    chkb("ov_flag", bus.overflow, 1'b1);
    chkb("ov_conv", bus.conv_ready, 1'b0);
    bus.rd_en_A = 1; bus.rd_addr_A = 5'd0;
    cyc(); chkd("ov_rd_intact", bus.rd_data_A[0 +: DW], 32'd2000);

    // async reset mid-traffic: outputs clear without waiting for an edge
    cyc();
    #2 reset = 0;
    #1;
    chkb("ar_overflow", bus.overflow, 1'b0);
    chkb("ar_conv", bus.conv_ready, 1'b1);
    chkb("ar_start", bus.start_to_next, 1'b0);
    chkb("ar_endp", bus.end_to_previous, 1'b0);
    chkw("ar_rd_a", bus.rd_data_A, '0);
    chkw("ar_rd_b", bus.rd_data_B, '0);
    cyc(); reset = 1;
    cyc(); chkb("ar_conv_after", bus.conv_ready, 1'b1);

    // simultaneous wr_done + release while both banks full
    write_frame(4000);
    wait_start("sim_start_a");
    write_frame(5000);
    cyc(); chkb("sim_full", bus.conv_ready, 1'b0);
    bus.wr_done = 1; bus.end_from_next = 1;
    cyc();
    chkb("sim_no_ovf", bus.overflow, 1'b0);
    chkb("sim_still_full", bus.conv_ready, 1'b0);
    cyc();
    chkb("sim_restart", bus.start_to_next, 1'b1);
    bus.rd_en_A = 1; bus.rd_addr_A = 5'd20;
    cyc(); chkd("sim_rd_next", bus.rd_data_A[15*DW +: DW], 32'd6520);

    // spurious release while idle is ignored
    do_reset();
    bus.end_from_next = 1;
    cyc(); cyc();
    chkb("sp_endp", bus.end_to_previous, 1'b0);
    chkb("sp_conv", bus.conv_ready, 1'b1);
    chkb("sp_start", bus.start_to_next, 1'b0);

    // randomized traffic, several mixes of producer/consumer speed
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        cyc();
        bus.wr_en     = ($urandom_range(0, 3) < 3 - blk % 3);
        bus.wr_addr   = AW'($urandom_range(0, 31));
        for (int k = 0; k < N; k++) bus.wr_data[k*DW +: DW] = $urandom();
        bus.wr_done   = ($urandom_range(0, 15) == 0);
        bus.end_from_next = ($urandom_range(0, 7) < 1 + blk);
        bus.rd_en_A   = $urandom_range(0, 1) == 1;
        bus.rd_en_B   = $urandom_range(0, 1) == 1;
        bus.rd_addr_A = AW'($urandom_range(0, 31));
        bus.rd_addr_B = AW'($urandom_range(0, 31));
      end
    end
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
